// File: rtl/bram_scan_reader.sv
// Scans a block RAM address range and streams each byte downstream over a
// valid/ready handshake, one read at a time, optionally looping forever.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     begin a scan (accepted only when idle)
//   loop_en                   wrap back to first_addr instead of finishing
//   first_addr, last_addr     inclusive scan bounds, latched on start
//   mem_addr, mem_we, mem_dout RAM read port (write enable tied low)
//   out_data, out_valid, out_ready  downstream byte stream
//   busy, done                scan in progress / end-of-scan pulse
module bram_scan_reader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned GAP    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_GAPW = 2'd3;

    localparam int unsigned LAT_W = 2;
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    logic [1:0]        state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [ADDR_W-1:0] first_q, first_n;
    logic [ADDR_W-1:0] last_q, last_n;
    logic [LAT_W-1:0]  lat_cnt, lat_n;
    logic [GAP_W-1:0]  gap_cnt, gap_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n;
    logic              busy_n;
    logic              done_n;

    assign mem_we = 1'b0;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_addr  <= '0;
            first_q   <= '0;
            last_q    <= '0;
            lat_cnt   <= '0;
            gap_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            mem_addr  <= addr_n;
            first_q   <= first_n;
            last_q    <= last_n;
            lat_cnt   <= lat_n;
            gap_cnt   <= gap_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        addr_n  = mem_addr;
        first_n = first_q;
        last_n  = last_q;
        lat_n   = lat_cnt;
        gap_n   = gap_cnt;
        data_n  = out_data;
        valid_n = out_valid;
        done_n  = 1'b0;

        case (state)
            S_IDLE: begin
                // busy stays high through the done cycle, so a start
                // coinciding with done is ignored
                if (start && !busy) begin
                    first_n = first_addr;
                    last_n  = last_addr;
                    addr_n  = first_addr;
                    lat_n   = '0;
                    state_n = S_READ;
                end
            end
            S_READ: begin
                if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
                    data_n  = mem_dout;
                    valid_n = 1'b1;
                    state_n = S_HOLD;
                end else begin
                    lat_n = lat_cnt + LAT_W'(1);
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    valid_n = 1'b0;
                    if (mem_addr == last_q && !loop_en) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        // natural ADDR_W overflow gives the modulo wrap
                        addr_n  = (mem_addr == last_q) ? first_q
                                                       : mem_addr + ADDR_W'(1);
                        lat_n   = '0;
                        gap_n   = '0;
                        state_n = (GAP > 0) ? S_GAPW : S_READ;
                    end
                end
            end
            S_GAPW: begin
                if (gap_cnt == GAP_W'(GAP - 1)) begin
                    lat_n   = '0;
                    state_n = S_READ;
                end else begin
                    gap_n = gap_cnt + GAP_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE) || done_n;
    end

endmodule

// File: tb/tb_bram_scan_reader.sv
module tb_bram_scan_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic       loop_en = 1'b0;
    logic [3:0] first_addr = '0;
    logic [3:0] last_addr = '0;
    logic       out_ready = 1'b1;
    logic       out_ready2 = 1'b1;

    logic [3:0] mem_addr, mem_addr2;
    logic       mem_we, mem_we2;
    logic [7:0] mem_dout, mem_dout2;
    logic [7:0] out_data, out_data2;
    logic       out_valid, out_valid2;
    logic       busy, busy2, done, done2;

    logic [7:0] ram [16];
    logic [3:0] a1_d, a2_d;

    int total = 0;
    int bad = 0;
    logic [7:0] got [$];
    int exp_q [$];
    int done_cnt;

    always #5 clk = ~clk;

    // Two-cycle-latency RAM models: one address register plus registered out_data
    always @(posedge clk) begin
        a1_d <= mem_addr;
        a2_d <= mem_addr2;
    end
    assign mem_dout  = ram[a1_d];
    assign mem_dout2 = ram[a2_d];

    bram_scan_reader #(.ADDR_W(4), .DATA_W(8), .RD_LAT(2), .GAP(0)) dut (
        .clk(clk), .rst(rst), .start(start), .loop_en(loop_en),
        .first_addr(first_addr), .last_addr(last_addr),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_dout(mem_dout),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    bram_scan_reader #(.ADDR_W(4), .DATA_W(8), .RD_LAT(2), .GAP(3)) dut_gap (
        .clk(clk), .rst(rst), .start(start2), .loop_en(1'b0),
        .first_addr(first_addr), .last_addr(last_addr),
        .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_dout(mem_dout2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] f, input logic [3:0] l, input logic le);
        first_addr = f;
        last_addr  = l;
        loop_en    = le;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_addr", 32'(mem_addr), 32'(f));
    endtask

    // Runs until one cycle after done, recording accepted bytes.
    task automatic run(input int budget, input int stall_byte, input int drop_at,
                       input bit check_period);
        int cyc = 0;
        int last_hs = -1;
        int stall = 0;
        bit seen_done = 1'b0;
        bit prev_v = 1'b0;
        bit prev_hs = 1'b0;
        logic [7:0] prev_d = '0;
        got.delete();
        done_cnt = 0;
        while (cyc < budget) begin
            tick();
            cyc++;
            if (prev_v && !prev_hs) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'(out_data), 32'(prev_d));
            end
            if (seen_done) begin
                chk("busy_after_done", 32'(busy), 32'd0);
                chk("done_one_cycle", 32'(done), 32'd0);
                break;
            end
            if (done) begin
                done_cnt++;
                seen_done = 1'b1;
                chk("busy_in_done", 32'(busy), 32'd1);
            end
            if (drop_at >= 0 && got.size() == drop_at) loop_en = 1'b0;
            out_ready = !(stall_byte >= 0 && out_valid &&
                          out_data == 8'(stall_byte) && stall < 7);
            if (!out_ready) stall++;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (check_period && last_hs >= 0)
                    chk("period", 32'(cyc - last_hs), 32'd3);
                last_hs = cyc;
            end
            prev_v  = out_valid;
            prev_hs = out_valid && out_ready;
            prev_d  = out_data;
        end
        if (!seen_done) chk("run_timeout", 32'd0, 32'd1);
        if (stall_byte >= 0) chk("stall_cycles", 32'(stall), 32'd7);
        out_ready = 1'b1;
    endtask

    task automatic cmp_bytes(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk(tag, 32'(got[i]), 32'(8'h10 + exp_q[i]));
        chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        int cyc;
        int hs_cyc [$];
        for (int i = 0; i < 16; i++) ram[i] = 8'(8'h10 + i);

        // Reset values
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("mem_we", 32'(mem_we), 32'd0);
        rst = 1'b0;
        tick();

        // Full scan 0..15
        do_start(4'd0, 4'd15, 1'b0);
        run(200, -1, -1, 1'b1);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
        cmp_bytes("full");
        chk("idle_addr_holds", 32'(mem_addr), 32'd15);

        // Backpressure on 0x14
        do_start(4'd3, 4'd5, 1'b0);
        run(100, 8'h14, -1, 1'b0);
        exp_q = '{3, 4, 5};
        cmp_bytes("stall");

        // Wrapping bounds 14..1
        do_start(4'd14, 4'd1, 1'b0);
        run(100, -1, -1, 1'b0);
        exp_q = '{14, 15, 0, 1};
        cmp_bytes("wrap");

        // Single-byte scan
        do_start(4'd9, 4'd9, 1'b0);
        run(50, -1, -1, 1'b0);
        exp_q = '{9};
        cmp_bytes("single");

        // Loop 0..2, drop loop_en while the second address-1 byte is held
        do_start(4'd0, 4'd2, 1'b1);
        run(100, -1, 4, 1'b0);
        exp_q = '{0, 1, 2, 0, 1, 2};
        cmp_bytes("loop");

        // Reset while holding address 7
        do_start(4'd0, 4'd15, 1'b0);
        cyc = 0;
        while (!(out_valid && mem_addr == 4'd7) && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("reach_addr7", 32'(out_valid && mem_addr == 4'd7), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        do_start(4'd0, 4'd3, 1'b0);
        run(100, -1, -1, 1'b1);
        exp_q = '{0, 1, 2, 3};
        cmp_bytes("rescan");

        // GAP=3 instance: handshakes 6 cycles apart
        first_addr = 4'd0;
        last_addr  = 4'd3;
        start2     = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0;
        got.delete();
        while (!done2 && cyc < 200) begin
            tick();
            cyc++;
            if (out_valid2 && out_ready2) begin
                got.push_back(out_data2);
                hs_cyc.push_back(cyc);
            end
        end
        chk("gap_done", 32'(done2), 32'd1);
        chk("gap_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size(); i++)
            chk("gap_data", 32'(got[i]), 32'(8'h10 + i));
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("gap_period", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
